// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit load path: access size, FSM states,
// and the byte-count helper used by both the decoder and the extender.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } state_e;

  // Number of bytes moved by an access of the given size.
  function automatic logic [3:0] bytes_of(size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_load_unit_if.sv
// Request, memory-read and response channels of the load unit.
// master: the load unit itself; slave: the core/memory environment around it.
interface lsu_load_unit_if #(
  parameter int XLEN = 32,
  parameter int AW   = 32
);
  logic            i_req_valid;
  logic            o_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic [1:0]      i_req_size;
  logic            i_req_unsigned;
  logic            o_mem_valid;
  logic            i_mem_ready;
  logic [AW-1:0]   o_mem_addr;
  logic            i_mem_rvalid;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_rsp_err;

  modport master (
    input  i_req_valid, i_req_addr, i_req_size, i_req_unsigned,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
    output o_req_ready, o_mem_valid, o_mem_addr, o_rsp_valid, o_rsp_data, o_rsp_err
  );

  modport slave (
    output i_req_valid, i_req_addr, i_req_size, i_req_unsigned,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_rsp_ready,
    input  o_req_ready, o_mem_valid, o_mem_addr, o_rsp_valid, o_rsp_data, o_rsp_err
  );
endinterface

// File: rtl/load_extend.sv
// Combinational load data extraction: shift the two-beat window {hi,lo} down
// by the byte offset, keep the accessed bytes and sign/zero-extend the rest.
module load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              hi,
  input  logic [XLEN-1:0]              lo,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  size_e                        size,
  input  logic                         is_unsigned,
  output logic [XLEN-1:0]              result
);

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic            sign;

  // Align, pick the sign bit of the accessed field, then merge field and fill.
  always_comb begin
    shifted = XLEN'({hi, lo} >> (8 * offset));
    case (size)
      SZ_B:    begin keep = XLEN'(8'hFF);         sign = shifted[7];      end
      SZ_H:    begin keep = XLEN'(16'hFFFF);      sign = shifted[15];     end
      SZ_W:    begin keep = XLEN'(32'hFFFF_FFFF); sign = shifted[31];     end
      default: begin keep = '1;                   sign = shifted[XLEN-1]; end
    endcase
    result = (shifted & keep) | ({XLEN{sign & ~is_unsigned}} & ~keep);
  end

endmodule

// File: rtl/lsu_load_unit.sv
// Load path between execute and data memory: one outstanding load, one or two
// beat-aligned reads, extended result returned over valid/ready.
// Build option LSU_MISALIGN_SPLIT_EN: misaligned loads are legal and loads that
// cross a beat boundary are split into two reads; without it misaligned loads
// return an error with no memory access.
module lsu_load_unit
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  lsu_load_unit_if.master bus
);

  localparam int BEAT = XLEN / 8;
  localparam int OW   = $clog2(BEAT);

  state_e          state, state_nx;
  logic [AW-1:0]   addr_q;
  size_e           size_q;
  logic            uns_q;
  logic            err_q;
  logic            cross_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] hi_q;

  size_e           req_size;
  logic [OW-1:0]   req_off;
  logic            req_illegal;
  logic            req_err;
  logic            req_cross;
`ifdef LSU_MISALIGN_SPLIT_EN
  logic [4:0]      req_end;
`else
  logic            req_misal;
`endif

  logic [AW-1:0]   beat0;
  logic [AW-1:0]   beat1;
  logic [XLEN-1:0] ext_data;

  // Classify the incoming request: illegal size, misalignment, beat crossing.
  always_comb begin
    req_size    = size_e'(bus.i_req_size);
    req_off     = bus.i_req_addr[OW-1:0];
    req_illegal = (XLEN == 32) && (req_size == SZ_D);
`ifdef LSU_MISALIGN_SPLIT_EN
    req_end     = 5'(req_off) + 5'(bytes_of(req_size));
    req_cross   = req_end > 5'(BEAT);
    req_err     = req_illegal;
`else
    req_misal   = (4'(req_off) & (bytes_of(req_size) - 4'd1)) != 4'd0;
    req_cross   = 1'b0;
    req_err     = req_illegal | req_misal;
`endif
  end

  // Beat addresses; the second beat wraps modulo 2^AW.
  always_comb begin
    beat0 = {addr_q[AW-1:OW], {OW{1'b0}}};
    beat1 = beat0 + AW'(BEAT);
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .hi          (hi_q),
    .lo          (lo_q),
    .offset      (addr_q[OW-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ext_data)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state and all outputs; outputs are zero outside their owning state.
  always_comb begin
    state_nx        = state;
    bus.o_req_ready = 1'b0;
    bus.o_mem_valid = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_rsp_valid = 1'b0;
    bus.o_rsp_err   = 1'b0;
    bus.o_rsp_data  = '0;
    case (state)
      S_IDLE: begin
        bus.o_req_ready = 1'b1;
        if (bus.i_req_valid) state_nx = req_err ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        bus.o_mem_valid = 1'b1;
        bus.o_mem_addr  = beat0;
        if (bus.i_mem_ready) state_nx = S_WAIT0;
      end
      S_WAIT0: begin
        if (bus.i_mem_rvalid) state_nx = cross_q ? S_REQ1 : S_RESP;
      end
      S_REQ1: begin
        bus.o_mem_valid = 1'b1;
        bus.o_mem_addr  = beat1;
        if (bus.i_mem_ready) state_nx = S_WAIT1;
      end
      S_WAIT1: begin
        if (bus.i_mem_rvalid) state_nx = S_RESP;
      end
      S_RESP: begin
        bus.o_rsp_valid = 1'b1;
        bus.o_rsp_err   = err_q;
        bus.o_rsp_data  = err_q ? '0 : ext_data;
        if (bus.i_rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request capture and read-data capture; rvalid is only honoured while waiting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q  <= '0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      cross_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      if (state == S_IDLE && bus.i_req_valid) begin
        addr_q  <= bus.i_req_addr;
        size_q  <= req_size;
        uns_q   <= bus.i_req_unsigned;
        err_q   <= req_err;
        cross_q <= req_cross;
      end
      if (state == S_WAIT0 && bus.i_mem_rvalid) lo_q <= bus.i_mem_rdata;
      if (state == S_WAIT1 && bus.i_mem_rvalid) hi_q <= bus.i_mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_load_unit.sv
// Testbench for lsu_load_unit (XLEN=32): table of loads with known results,
// randomised loads against a byte-level memory model, and hand sequences for
// memory/response backpressure and reset during an outstanding read.
module tb_lsu_load_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst_n;

  lsu_load_unit_if #(.XLEN(32), .AW(32)) bus ();

  lsu_load_unit #(.XLEN(32), .AW(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rlat    = 0;
  int stall   = 0;
  int n_acc   = 0;

  logic [7:0]  mem_b [logic [31:0]];
  logic [31:0] exp_addr_q [$];
  rsp_t        exp_rsp_q [$];
  vec_t        vecs [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return mem_b.exists(a) ? mem_b[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  function automatic void wr_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_b[a + 32'(i)] = w[8*i +: 8];
  endfunction

  // Independent reference: assemble bytes one at a time and extend.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic u,
                                output logic [31:0] d, output logic e);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    e = (sz == 2'd3) || (!SPLIT && (a % 32'(n)) != 0);
    if (!e) begin
      for (int i = 0; i < n; i++) v = v | (32'(rd_byte(a + 32'(i))) << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    end
    d = e ? 32'h0 : v;
  endfunction

  // Push the beat addresses the DUT must issue; returns how many.
  function automatic int push_beats(input logic [31:0] a, input logic [1:0] sz);
    int n;
    logic [31:0] b0;
    n = 1 << sz;
    if (sz == 2'd3 || (!SPLIT && (a % 32'(n)) != 0)) return 0;
    b0 = a & 32'hFFFF_FFFC;
    exp_addr_q.push_back(b0);
    if (32'(a[1:0]) + 32'(n) > 32'd4) begin
      exp_addr_q.push_back(b0 + 32'd4);
      return 2;
    end
    return 1;
  endfunction

  // Memory model: accepts on valid&ready, returns data rlat cycles later.
  initial begin
    bit          acc;
    bit          pend;
    int          cnt;
    logic [31:0] a;
    logic [31:0] pdata;
    logic [31:0] e;
    pend = 0;
    cnt  = 0;
    pdata = '0;
    bus.i_mem_ready  = 1'b1;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc = bus.o_mem_valid && bus.i_mem_ready;
      a   = bus.o_mem_addr;
      @(posedge clk);
      #1;
      bus.i_mem_rvalid = 1'b0;
      if (acc && rst_n) begin
        n_acc++;
        if (exp_addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mem_unexpected: access at %08h, required no access", a);
        end else begin
          e = exp_addr_q.pop_front();
          check("mem_addr", a, e);
        end
        pend  = 1;
        cnt   = rlat;
        pdata = rd_word(a);
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.i_mem_rvalid = 1'b1;
          bus.i_mem_rdata  = pdata;
          pend = 0;
        end else begin
          cnt--;
        end
      end
      if (stall > 0) begin
        bus.i_mem_ready = 1'b0;
        stall--;
      end else begin
        bus.i_mem_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic u,
                      input logic [31:0] ed, input logic ee, input int st, output int nb);
    nb = push_beats(a, sz);
    exp_rsp_q.push_back('{ed, ee});
    @(negedge clk);
    bus.i_req_valid    = 1'b1;
    bus.i_req_addr     = a;
    bus.i_req_size     = sz;
    bus.i_req_unsigned = u;
    stall              = st;
    @(negedge clk);
    bus.i_req_valid    = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int cyc, output bit ok);
    cyc = 1;
    while (!bus.o_rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    ok = bus.o_rsp_valid;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no response after %0d cycles, required one", tag, cyc);
    end
  endtask

  task automatic check_rsp(input string tag);
    rsp_t r;
    if (exp_rsp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_sb: response with data %08h, required none", tag, bus.o_rsp_data);
    end else begin
      r = exp_rsp_q.pop_front();
      check({tag, "_data"}, bus.o_rsp_data, r.data);
      check({tag, "_err"}, bus.o_rsp_err, r.err);
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [31:0] ed, input logic ee);
    int    nb;
    int    cyc;
    bit    ok;
    string tag;
    tag = $sformatf("ld_%08h_s%0d_u%0d", a, sz, u);
    send(a, sz, u, ed, ee, 0, nb);
    wait_rsp(tag, cyc, ok);
    if (ok) begin
      check_rsp(tag);
      check({tag, "_lat"}, cyc, ee ? 1 : (nb == 2 ? 5 : 3));
    end
    @(posedge clk);
    check({tag, "_beats_left"}, exp_addr_q.size(), 0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rsz;
    logic        ru;
    logic [31:0] rd;
    logic        re;
    int          nb;
    int          cyc;
    int          seen;
    bit          ok;
    bit          spurious;

    rst_n              = 1'b0;
    bus.i_req_valid    = 1'b0;
    bus.i_req_addr     = '0;
    bus.i_req_size     = '0;
    bus.i_req_unsigned = 1'b0;
    bus.i_rsp_ready    = 1'b1;

    wr_word(32'h0000_1000, 32'h8012_3456);
    wr_word(32'h0000_1004, 32'h0000_00FF);
    wr_word(32'h0000_2000, 32'hBEEF_1234);
    wr_word(32'h0000_3000, 32'h4433_2211);
    wr_word(32'h0000_3004, 32'h8877_6655);
    wr_word(32'hFFFF_FFFC, 32'hA1B2_C3D4);
    wr_word(32'h0000_0000, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) wr_word(32'h0000_1008 + 32'(4 * i), $urandom);

    vecs.push_back('{32'h0000_1003, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{32'h0000_1003, 2'd0, 1'b1, 32'h0000_0080, 1'b0});
    vecs.push_back('{32'h0000_2002, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0});
    vecs.push_back('{32'h0000_2002, 2'd1, 1'b1, 32'h0000_BEEF, 1'b0});
    vecs.push_back('{32'h0000_3000, 2'd2, 1'b0, 32'h4433_2211, 1'b0});
    vecs.push_back('{32'h0000_3001, 2'd0, 1'b0, 32'h0000_0022, 1'b0});
    vecs.push_back('{32'h0000_3004, 2'd1, 1'b0, 32'h0000_6655, 1'b0});
    vecs.push_back('{32'h0000_3006, 2'd1, 1'b0, 32'hFFFF_8877, 1'b0});
    vecs.push_back('{32'h0000_3000, 2'd3, 1'b0, 32'h0000_0000, 1'b1});
`ifdef LSU_MISALIGN_SPLIT_EN
    vecs.push_back('{32'h0000_3002, 2'd2, 1'b0, 32'h6655_4433, 1'b0});
    vecs.push_back('{32'hFFFF_FFFE, 2'd2, 1'b0, 32'hF00D_A1B2, 1'b0});
    vecs.push_back('{32'h0000_1001, 2'd1, 1'b0, 32'h0000_1234, 1'b0});
    vecs.push_back('{32'h0000_1003, 2'd1, 1'b0, 32'hFFFF_FF80, 1'b0});
`else
    vecs.push_back('{32'h0000_3002, 2'd2, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'hFFFF_FFFE, 2'd2, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_1001, 2'd1, 1'b0, 32'h0000_0000, 1'b1});
    vecs.push_back('{32'h0000_1003, 2'd1, 1'b0, 32'h0000_0000, 1'b1});
`endif

    // Reset values, sampled while reset is held.
    repeat (2) @(negedge clk);
    check("rst_ctrl", {bus.o_req_ready, bus.o_mem_valid, bus.o_rsp_valid, bus.o_rsp_err}, 4'b1000);
    check("rst_mem_addr", bus.o_mem_addr, 0);
    check("rst_rsp_data", bus.o_rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_load(vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].data, vecs[i].err);

    for (int i = 0; i < 10; i++) begin
      ra  = 32'h0000_1000 + 32'($urandom_range(0, 23));
      rsz = 2'($urandom_range(0, 2));
      ru  = 1'($urandom_range(0, 1));
      model(ra, rsz, ru, rd, re);
      do_load(ra, rsz, ru, rd, re);
    end

    // Memory backpressure: ready low for 4 cycles, address must hold.
    send(32'h0000_2002, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0, 4, nb);
    cyc  = 1;
    seen = 0;
    while (!bus.o_rsp_valid && cyc < 60) begin
      if (bus.o_mem_valid && !bus.i_mem_ready) begin
        seen++;
        check("bp_mem_addr", bus.o_mem_addr, 32'h0000_2000);
      end
      @(negedge clk);
      cyc++;
    end
    check("bp_stall_cycles", seen, 4);
    check("bp_lat", cyc, 7);
    if (bus.o_rsp_valid) check_rsp("bp");
    @(posedge clk);

    // Response backpressure: rsp_ready low for 5 cycles.
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    send(32'h0000_3000, 2'd2, 1'b1, 32'h4433_2211, 1'b0, 0, nb);
    wait_rsp("rbp", cyc, ok);
    for (int i = 0; i < 5; i++) begin
      check("rbp_valid", bus.o_rsp_valid, 1);
      check("rbp_data", bus.o_rsp_data, 32'h4433_2211);
      check("rbp_req_ready", bus.o_req_ready, 0);
      @(negedge clk);
    end
    check_rsp("rbp");
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    check("rbp_idle_after", {bus.o_req_ready, bus.o_rsp_valid}, 2'b10);

    // Reset while a read is outstanding (second beat when splitting is enabled).
    rlat = 4;
`ifdef LSU_MISALIGN_SPLIT_EN
    ra = 32'h0000_3002;
`else
    ra = 32'h0000_3000;
`endif
    seen = n_acc;
    send(ra, 2'd2, 1'b0, 32'h0, 1'b0, 0, nb);
    cyc = 0;
    while (n_acc < seen + nb && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("rstmid_beats_issued", n_acc - seen, nb);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_ctrl", {bus.o_mem_valid, bus.o_rsp_valid, bus.o_rsp_err}, 3'b000);
    check("rstmid_mem_addr", bus.o_mem_addr, 0);
    check("rstmid_rsp_data", bus.o_rsp_data, 0);
    exp_rsp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_rsp_valid || bus.o_mem_valid) spurious = 1;
    end
    check("rstmid_late_rvalid_ignored", spurious, 0);
    rlat = 0;
    do_load(32'h0000_0000, 2'd2, 1'b0, 32'h0BAD_F00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
